i2c_req_arbiter: RTL
====================

Name: i2c_req_arbiter

Overview:
- Shares one i2c_master instance between NREQ requesters. Each requester asks for a single-byte read or write.
- Round-robin arbitration picks one requester. The block then drives the master's cmd/inp load sequence and watches the bus for completion.
- When the transfer finishes, the block returns read data and the ACK status to the winning requester.
- Sits between requester logic and the i2c_master cmd/inp/out/stat port, and taps the SCL/SDA wires.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- IDLE_CYC, 16: consecutive clk cycles of SDA and SCL both high that mark the end of a transfer. Must be greater than 10.
- TIMEOUT, 1024: cycle limit for the wait states. Used only when the optional timeout is compiled in.

Ports:
- clk  in  1  system clock, same clock as i2c_master.
- rst  in  1  asynchronous reset, active-low.
- req  in  NREQ  request level per requester; held until done.
- req_rd  in  NREQ  1 = read, 0 = write, per requester.
- req_addr  in  7*NREQ  7-bit slave address per requester, packed with requester i at [7i+6:7i].
- req_wdata  in  8*NREQ  write byte per requester, packed.
- gnt  out  NREQ  one-hot grant; held from ARB until DONE.
- done  out  NREQ  one-cycle pulse to the granted requester.
- rdata  out  8  read byte; valid with done.
- ack_ok  out  1  master stat captured at done; write transfers only, 0 for reads.
- err  out  1  timeout flag; valid with done.
- m_cmd  out  3  to master cmd: 0 NONE, 1 ADDR, 2 DATA, 3 READ, 4 WRITE.
- m_inp  out  8  to master inp.
- m_out  in  8  from master out.
- m_stat  in  1  from master stat.
- bus_scl  in  1  observed SCL wire.
- bus_sda  in  1  observed SDA wire.

Behaviour:
- Reset (rst low, async): state IDLE, gnt=0, done=0, rdata=0, ack_ok=0, err=0, m_cmd=0, m_inp=0, rr_ptr=0, idle_cnt=0, to_cnt=0.
- bus_scl and bus_sda each pass through a 2-flop synchronizer. Only the synchronized values are used.
- m_cmd is 0 in every state except LD_ADDR, LD_DATA and GO. Each of those states lasts exactly one cycle.
- IDLE: if any req bit is set, go to ARB.
- ARB: grant the first set req at or after rr_ptr, wrapping modulo NREQ. Latch the index, rd, addr and wdata. Set rr_ptr = index+1, wrapped. Next state LD_ADDR.
- LD_ADDR: m_cmd=1, m_inp={1'b0, addr}. Next LD_DATA.
- LD_DATA: m_cmd=2, m_inp=wdata. Issued for reads too. Next GO.
- GO: m_cmd=3 if rd, else 4. Next WAIT_START.
- WAIT_START: wait until synchronized SDA is 0 (start condition), then go to WAIT_STOP with idle_cnt=0.
- WAIT_STOP: idle_cnt increments while synced SDA and SCL are both 1, and clears otherwise. When idle_cnt reaches IDLE_CYC-1, go to DONE.
- DONE, one cycle:
  - done[idx]=1.
  - rdata = rd ? m_out : 0.
  - ack_ok = rd ? 0 : m_stat.
  - err = timeout flag.
  - gnt cleared at the end of this cycle. Next IDLE.
- Latency from GO to done is at least 1 + 2 (sync) + bus time + IDLE_CYC cycles.
- rdata, ack_ok and err hold their values until the next DONE.
- A req deasserted after grant does not abort the transfer. The transfer completes and done is still pulsed.
- A new req arriving while busy waits. No requester is granted twice in a row while another one is requesting.
- A single requester may be re-granted back-to-back, with one IDLE cycle between grants.
- Reset mid-transfer: the FSM returns to IDLE immediately and no done is pulsed. The master is reset by the same system reset.

Optional Feature:
- I2C_ARB_TIMEOUT_EN defined:
  - to_cnt counts cycles spent in WAIT_START plus WAIT_STOP.
  - When to_cnt reaches TIMEOUT-1, go to DONE with err=1 and rdata=0.
  - to_cnt clears in GO.
- I2C_ARB_TIMEOUT_EN not defined: no to_cnt, waits indefinitely, err is tied to 0.

Test Plan:
- req=4'b0001, write, addr 0x50, wdata 0xA5; slave ACKs -> m_cmd sequence 1/0x50, 2/0xA5, 4 on consecutive cycles; done[0] pulses once, ack_ok=1, err=0.
- req=4'b0100, read, addr 0x3C; slave returns 0x5A -> m_cmd 1, 2, 3; done[2] pulses with rdata=0x5A, ack_ok=0.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0; every done pulse goes to the currently granted index.
- Write to absent address 0x11 (no ACK) -> done pulses with ack_ok=0, err=0.
- Timeout build, TIMEOUT=64, bus SDA stuck high after GO -> done pulses 64 cycles after entering WAIT_START with err=1, rdata=0.
- rst driven low during WAIT_STOP -> gnt=0 and m_cmd=0 immediately; no done pulse; a new req after reset is granted normally.

Source files
------------

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one i2c_master between NREQ single-byte requesters.
// Optional wait-state timeout is compiled in with `define I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDLE_CYC = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rd,
    input  logic [7*NREQ-1:0] req_addr,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rdata,
    output logic              ack_ok,
    output logic              err,
    output logic [2:0]        m_cmd,
    output logic [7:0]        m_inp,
    input  logic [7:0]        m_out,
    input  logic              m_stat,
    input  logic              bus_scl,
    input  logic              bus_sda
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(IDLE_CYC);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NREQ - 1);

    if (NREQ < 2 || NREQ > 8 || IDLE_CYC <= 10 || TIMEOUT < 2) begin : g_param_check
        $error("i2c_req_arbiter: parameter out of range");
    end

    typedef enum logic [2:0] {
        IDLE, ARB, LD_ADDR, LD_DATA, GO, WAIT_START, WAIT_STOP, DONE
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_ADDR  = 3'd1,
        CMD_DATA  = 3'd2,
        CMD_READ  = 3'd3,
        CMD_WRITE = 3'd4
    } cmd_e;

    state_e          state, next_state;
    logic            scl_meta, scl_sync, sda_meta, sda_sync;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   idle_cnt;
    logic            cur_rd;
    logic [6:0]      cur_addr;
    logic [7:0]      cur_wdata;
    logic            win_found;
    logic [IW-1:0]   win;
    logic            win_rd;
    logic [6:0]      win_addr;
    logic [7:0]      win_wdata;
    logic            waiting;
    logic            timed_out;
    logic            bus_idle;

    assign waiting  = (state == WAIT_START) || (state == WAIT_STOP);
    assign bus_idle = sda_sync && scl_sync;

    // Synchronizers reset to the idle (high) bus level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
        end else begin
            scl_meta <= bus_scl;
            scl_sync <= scl_meta;
            sda_meta <= bus_sda;
            sda_sync <= sda_meta;
        end
    end

    // First set request at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        int unsigned c;
        win_found = 1'b0;
        win       = '0;
        win_rd    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            c = 32'(rr_ptr) + k;
            if (c >= unsigned'(NREQ)) c = c - unsigned'(NREQ);
            if (!win_found && req[IW'(c)]) begin
                win_found = 1'b1;
                win       = IW'(c);
            end
        end
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IW'(k) == win) begin
                win_rd    = req_rd[k];
                win_addr  = req_addr[7*k +: 7];
                win_wdata = req_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (|req) next_state = ARB;
            ARB:        next_state = win_found ? LD_ADDR : IDLE;
            LD_ADDR:    next_state = LD_DATA;
            LD_DATA:    next_state = GO;
            GO:         next_state = WAIT_START;
            WAIT_START: begin
                if (timed_out)      next_state = DONE;
                else if (!sda_sync) next_state = WAIT_STOP;
            end
            WAIT_STOP: begin
                if (timed_out)                            next_state = DONE;
                else if (bus_idle && idle_cnt == IDLE_LAST) next_state = DONE;
            end
            DONE:       next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        m_cmd = CMD_NONE;
        m_inp = '0;
        done  = '0;
        case (state)
            LD_ADDR: begin
                m_cmd = CMD_ADDR;
                m_inp = {1'b0, cur_addr};
            end
            LD_DATA: begin
                m_cmd = CMD_DATA;
                m_inp = cur_wdata;
            end
            GO:      m_cmd = cur_rd ? CMD_READ : CMD_WRITE;
            DONE:    done = gnt;
            default: ;
        endcase
    end

    // Results are captured on entry to DONE so they are already valid alongside the done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            rr_ptr    <= '0;
            cur_rd    <= 1'b0;
            cur_addr  <= '0;
            cur_wdata <= '0;
            idle_cnt  <= '0;
            rdata     <= '0;
            ack_ok    <= 1'b0;
        end else begin
            if (state == ARB && win_found) begin
                gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                rr_ptr    <= (win == IDX_LAST) ? '0 : win + 1'b1;
                cur_rd    <= win_rd;
                cur_addr  <= win_addr;
                cur_wdata <= win_wdata;
            end
            if (state == DONE) gnt <= '0;

            if (state == WAIT_STOP && bus_idle) idle_cnt <= idle_cnt + 1'b1;
            else                                idle_cnt <= '0;

            if (next_state == DONE) begin
                rdata  <= (cur_rd && !timed_out) ? m_out : '0;
                ack_ok <= cur_rd ? 1'b0 : m_stat;
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] to_cnt;

    assign timed_out = waiting && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == GO)  to_cnt <= '0;
            else if (waiting) to_cnt <= to_cnt + 1'b1;
            if (next_state == DONE) err <= timed_out;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

endmodule
